// File: rtl/add32_pipe_rv.sv
// Two-stage elastic adder: operand register (p0) feeding a sum register (p1),
// with valid/ready flow control on both sides and a combinational ready path.
module add32_pipe_rv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry,
    output logic [1:0]       occupancy
);

    logic             p0_valid_q, p0_valid_d;
    logic [WIDTH-1:0] p0_a_q, p0_a_d;
    logic [WIDTH-1:0] p0_b_q, p0_b_d;
    logic             p1_valid_q, p1_valid_d;
    logic [WIDTH-1:0] p1_c_q, p1_c_d;
    logic             p1_carry_q, p1_carry_d;

    logic             out_fire;
    logic             p1_load;
    logic             in_fire;
    logic [WIDTH:0]   sum;

    // p0 drains whenever p1 is empty or is handing its result off this cycle.
    assign out_fire = p1_valid_q & out_ready;
    assign p1_load  = p0_valid_q & (~p1_valid_q | out_ready);
    assign in_ready = ~p0_valid_q | p1_load;
    assign in_fire  = in_valid & in_ready;
    assign sum      = {1'b0, p0_a_q} + {1'b0, p0_b_q};

    always_comb begin
        p0_valid_d = p0_valid_q;
        p0_a_d     = p0_a_q;
        p0_b_d     = p0_b_q;
        if (in_fire) begin
            p0_valid_d = 1'b1;
            p0_a_d     = a;
            p0_b_d     = b;
        end else if (p1_load) begin
            p0_valid_d = 1'b0;
        end
    end

    always_comb begin
        p1_valid_d = p1_valid_q;
        p1_c_d     = p1_c_q;
        p1_carry_d = p1_carry_q;
        if (p1_load) begin
            p1_valid_d = 1'b1;
            p1_c_d     = sum[WIDTH-1:0];
            p1_carry_d = sum[WIDTH];
        end else if (out_fire) begin
            p1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_valid_q <= 1'b0;
            p0_a_q     <= '0;
            p0_b_q     <= '0;
            p1_valid_q <= 1'b0;
            p1_c_q     <= '0;
            p1_carry_q <= 1'b0;
        end else begin
            p0_valid_q <= p0_valid_d;
            p0_a_q     <= p0_a_d;
            p0_b_q     <= p0_b_d;
            p1_valid_q <= p1_valid_d;
            p1_c_q     <= p1_c_d;
            p1_carry_q <= p1_carry_d;
        end
    end

    assign out_valid = p1_valid_q;
    assign c         = p1_c_q;
    assign carry     = p1_carry_q;
    assign occupancy = {1'b0, p0_valid_q} + {1'b0, p1_valid_q};

endmodule

// File: doc/add32_pipe_rv.md
# add32_pipe_rv

Two-stage valid/ready pipelined adder that wraps a combinational WIDTH-bit add. It provides flow control at both ends: upstream producers hand in operand pairs, and downstream consumers may apply backpressure. It is the elastic counterpart of the free-running pipeline wrapper and sits between a stream producer and a consumer that can stall. Full throughput (one result per cycle) when unstalled, and no transaction is ever dropped or duplicated.

## Interface
- WIDTH, 32, operand/result width in bits (≥1)
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair a/b valid this cycle
- in_ready  output  1  block accepts operand pair this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result c/carry valid
- out_ready  input  1  consumer accepts result this cycle
- c  output  WIDTH  sum (a + b) mod 2^WIDTH
- carry  output  1  carry-out of a + b
- occupancy  output  2  in-flight transactions, 0..2

## Operation
- Stage 0 (p0): registers p0_valid, p0_a, p0_b.
- Stage 1 (p1): registers p1_valid, p1_c, p1_carry, loaded with the WIDTH+1-bit sum {carry, c} = p0_a + p0_b (zero-extended add).
- Outputs: out_valid = p1_valid, c = p1_c, carry = p1_carry; all are driven directly from flops.
- Handshake terms:
  - out_fire = out_valid & out_ready
  - p1_load = p0_valid & (~p1_valid | out_ready)
  - in_ready = ~p0_valid | p1_load
  - in_fire = in_valid & in_ready
- p0 update:
  - if in_fire, load a/b and set p0_valid = 1;
  - else if p1_load, clear p0_valid;
  - else hold.
- p1 update:
  - if p1_load, load sum and set p1_valid = 1;
  - else if out_fire, clear p1_valid;
  - else hold.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_valid, or from a/b to c.
- occupancy = p0_valid + p1_valid, driven combinationally from flops.
- Data regs load only on their load condition; they are don't-care when the matching valid is 0, but still reset to 0.
- Stall hold: while out_valid=1 and out_ready=0, c and carry stay stable until out_fire. Producer-side rule: the block ignores a/b when in_ready=0 and makes no assumption about them.
- Arithmetic: unsigned and wrap-around. For example, all-ones + 1 gives c=0, carry=1.

## Timing
- Reset (async assert, any time): p0_valid, p1_valid, out_valid, in-flight data, c, carry and occupancy all go to 0 immediately.
  - in_ready = 1 during and after reset.
  - Any transactions in flight at reset are discarded.
  - Release is synchronous to clk; the first accept is possible at the first posedge after deassert.
- Latency: a transaction accepted at posedge N is presented with out_valid=1 after posedge N+1, i.e. two edges, when unstalled.
- Throughput: 1 transaction/cycle while out_ready=1.
- Full (p0_valid=p1_valid=1):
  - with out_ready=0, in_ready=0 and the pipeline holds;
  - with out_ready=1, the same edge does out_fire, p1_load and in_fire (full pass-through, occupancy stays 2).
- Empty: out_valid=0 and in_ready=1. out_ready is ignored.
- Simultaneous in_fire and p1_load: p0 takes the new data, p1 takes the old p0 data.
- Bubble collapse: with p1 stalled and p0 empty, one more transaction is accepted into p0, then in_ready drops.

## Test plan
- Single transaction: a=5, b=7, out_ready=1 -> out_valid high 2 edges after accept, c=12, carry=0, then occupancy returns to 0.
- Wrap: a=0xFFFFFFFF, b=1 -> c=0x00000000, carry=1; a=0x80000000, b=0x80000000 -> c=0, carry=1.
- Streaming: 100 back-to-back pairs (a=i, b=3i), out_ready=1 -> in_ready constantly 1, 100 results in order, c=4i, one per cycle.
- Backpressure: stream with out_ready=0 for 5 cycles -> exactly 2 accepted, then in_ready=0, occupancy=2, c stable; release out_ready -> results in order with no loss or duplication.
- Random in_valid/out_ready (50% each, 10k cycles) against a scoreboard -> every accepted pair yields exactly one correct in-order result, and occupancy always equals accepted minus delivered.
- Reset mid-stream: assert rst with occupancy=2 -> out_valid=0, occupancy=0, in_ready=1 immediately (without waiting for an edge); after release the next transaction a=1, b=2 yields c=3 with no stale result emitted.
